mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 150 +++++++++++++++
 tb/tb_mem_responder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-mapped responder: edge-triggered RAM reads/writes, a display register,
// and a debounced switch read that waits for a confirm press-and-release on SW[17].
module mem_responder #(
  parameter int WORD_LENGTH = 32,
  parameter int ARG_LENGTH  = 8,
  parameter int PC_ADDR     = 0,
  parameter int DISP_ADDR   = 1,
  parameter int SWITCH_ADDR = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   read_clock,
  input  logic [ARG_LENGTH-1:0]  read_from,
  output logic [WORD_LENGTH-1:0] q,
  output logic                   read_valid,
  input  logic                   write_clock,
  input  logic [ARG_LENGTH-1:0]  write_into,
  input  logic [WORD_LENGTH-1:0] data,
  input  logic [17:0]            SW,
  output logic [WORD_LENGTH-1:0] displaying,
  output logic                   busy,
  output logic                   overrun
);

  localparam int DEPTH = 2 ** ARG_LENGTH;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [ARG_LENGTH-1:0] DISP_A   = ARG_LENGTH'(DISP_ADDR);
  localparam logic [ARG_LENGTH-1:0] SWITCH_A = ARG_LENGTH'(SWITCH_ADDR);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    IDLE,
    MEM_READ,
    SW_WAIT_HIGH,
    SW_WAIT_LOW,
    RESPOND
  } state_t;

  state_t state, state_next;

  logic                   read_prev;
  logic                   write_prev;
  logic                   read_edge;
  logic                   write_edge;
  logic                   read_accept;
  logic                   high_done;
  logic                   low_done;
  logic [ARG_LENGTH-1:0]  read_addr;
  logic [CNT_W-1:0]       cnt;
  logic [WORD_LENGTH-1:0] mem [DEPTH];

  // Edge registers reset high so a strobe held across reset release is not seen as an edge.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      read_prev  <= 1'b1;
      write_prev <= 1'b1;
    end else begin
      read_prev  <= read_clock;
      write_prev <= write_clock;
    end
  end

  assign read_edge   = read_clock & ~read_prev;
  assign write_edge  = write_clock & ~write_prev;
  assign read_accept = read_edge && (state == IDLE);
  assign high_done   = (state == SW_WAIT_HIGH) && SW[17] && (cnt == CNT_LAST);
  assign low_done    = (state == SW_WAIT_LOW) && !SW[17] && (cnt == CNT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (write_edge && (write_into != SWITCH_A)) begin
      mem[write_into] <= data;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      displaying <= '0;
      overrun    <= 1'b0;
      read_addr  <= '0;
    end else begin
      if (write_edge && (write_into == DISP_A)) begin
        displaying <= data;
      end
      if (read_edge && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      if (read_accept) begin
        read_addr <= read_from;
      end
    end
  end

  // Counts consecutive samples of the level the current wait state is looking for.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      case (state)
        SW_WAIT_HIGH: begin
          if (!SW[17] || high_done) cnt <= '0;
          else                      cnt <= cnt + 1'b1;
        end
        SW_WAIT_LOW: begin
          if (SW[17] || low_done) cnt <= '0;
          else                    cnt <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (state == MEM_READ) begin
      q <= mem[read_addr];
    end else if (high_done) begin
      q <= WORD_LENGTH'(SW[16:0]);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (read_edge) begin
          state_next = (read_from == SWITCH_A) ? SW_WAIT_HIGH : MEM_READ;
        end
      end
      MEM_READ:     state_next = RESPOND;
      SW_WAIT_HIGH: if (high_done) state_next = SW_WAIT_LOW;
      SW_WAIT_LOW:  if (low_done) state_next = RESPOND;
      RESPOND:      state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  // busy covers the accepting edge cycle itself so the initiator sees it immediately.
  always_comb begin
    busy       = (state != IDLE) || read_edge;
    read_valid = (state == RESPOND);
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder: a memory model predicts each
// read response and its cycle, and a monitor checks every read_valid pulse.
module tb_mem_responder;

  localparam int WL   = 32;
  localparam int AL   = 8;
  localparam int DISP = 1;
  localparam int SWA  = 2;
  localparam int DEB  = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          read_clock;
  logic [AL-1:0] read_from;
  logic [WL-1:0] q;
  logic          read_valid;
  logic          write_clock;
  logic [AL-1:0] write_into;
  logic [WL-1:0] data;
  logic [17:0]   SW;
  logic [WL-1:0] displaying;
  logic          busy;
  logic          overrun;

  always #5 clock = ~clock;

  mem_responder #(
    .WORD_LENGTH(WL), .ARG_LENGTH(AL), .PC_ADDR(0),
    .DISP_ADDR(DISP), .SWITCH_ADDR(SWA), .DEBOUNCE(DEB)
  ) dut (
    .CLOCK_50(clock), .reset_n(reset_n), .read_clock(read_clock),
    .read_from(read_from), .q(q), .read_valid(read_valid),
    .write_clock(write_clock), .write_into(write_into), .data(data),
    .SW(SW), .displaying(displaying), .busy(busy), .overrun(overrun)
  );

  typedef struct {
    logic [WL-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [WL-1:0] ref_mem [256];
  bit            written [256];
  logic [WL-1:0] exp_disp;
  bit            exp_overrun;
  int            busy_until;
  bit            sw_pat [40];
  logic [16:0]   sw_val [40];
  int            pat_len;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [WL-1:0] actual,
                              input logic [WL-1:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push_expect(input logic [WL-1:0] d, input int at_cyc);
    exp_t e;
    e.data = d;
    e.cyc  = at_cyc;
    sb.push_back(e);
  endtask

  // Every read_valid pulse must match the oldest outstanding prediction in value and cycle.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && read_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_read_valid: got pulse with q=%h at cycle %0d, required none", q, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("read_data", q, e.data);
        check_output("read_cycle", WL'(cyc), WL'(e.cyc));
      end
    end
  end

  // One strobe cycle followed by one quiet cycle; the reference model is updated at issue time.
  task automatic apply_stimulus(input bit rd, input logic [AL-1:0] ra, input bit wr,
                                input logic [AL-1:0] wa, input logic [WL-1:0] wd);
    int c;
    @(posedge clock); #1;
    c           = cyc;
    read_clock  = rd;
    read_from   = ra;
    write_clock = wr;
    write_into  = wa;
    data        = wd;
    if (wr && wa != AL'(SWA)) begin
      ref_mem[wa] = wd;
      written[wa] = 1'b1;
      if (wa == AL'(DISP)) exp_disp = wd;
    end
    if (rd) begin
      if (c <= busy_until) begin
        exp_overrun = 1'b1;
      end else begin
        push_expect(ref_mem[ra], c + 2);
        busy_until = c + 2;
      end
    end
    @(posedge clock); #1;
    read_clock  = 1'b0;
    write_clock = 1'b0;
  endtask

  task automatic read_with_busy_check(input logic [AL-1:0] ra);
    int c;
    @(posedge clock); #1;
    c          = cyc;
    read_clock = 1'b1;
    read_from  = ra;
    push_expect(ref_mem[ra], c + 2);
    busy_until = c + 2;
    @(negedge clock);
    check_output("busy_edge_cycle", WL'(busy), 1);
    @(posedge clock); #1;
    read_clock = 1'b0;
    @(negedge clock);
    check_output("busy_mem_read", WL'(busy), 1);
    @(negedge clock);
    check_output("busy_respond", WL'(busy), 1);
    @(negedge clock);
    check_output("busy_released", WL'(busy), 0);
  endtask

  // Switch read driven by sw_pat/sw_val; the response is predicted by locating the
  // first run of DEB highs and the first run of DEB lows that follows it.
  task automatic switch_read(input int inject_at);
    int  c;
    int  hi;
    int  lo;
    bit  all_set;
    hi = -1;
    lo = -1;
    for (int k = DEB - 1; k < pat_len; k++) begin
      all_set = 1'b1;
      for (int m = k - DEB + 1; m <= k; m++) if (!sw_pat[m]) all_set = 1'b0;
      if (hi < 0 && all_set) hi = k;
    end
    for (int k = hi + DEB; k < pat_len; k++) begin
      all_set = 1'b1;
      for (int m = k - DEB + 1; m <= k; m++) if (sw_pat[m]) all_set = 1'b0;
      if (lo < 0 && all_set) lo = k;
    end
    @(posedge clock); #1;
    c          = cyc;
    read_clock = 1'b1;
    read_from  = AL'(SWA);
    push_expect(WL'(sw_val[hi]), c + 2 + lo);
    busy_until = c + 2 + lo;
    for (int k = 0; k < pat_len; k++) begin
      @(posedge clock); #1;
      read_clock = (k == inject_at);
      read_from  = 8'd5;
      SW         = {sw_pat[k], sw_val[k]};
      if (k == inject_at) exp_overrun = 1'b1;
    end
    @(posedge clock); #1;
    read_clock = 1'b0;
    SW[17]     = 1'b0;
  endtask

  task automatic load_pattern(input logic [15:0] bits, input int len,
                              input logic [16:0] v_early, input logic [16:0] v_late,
                              input int switch_at);
    pat_len = len;
    for (int k = 0; k < len; k++) begin
      sw_pat[k] = bits[len-1-k];
      sw_val[k] = (k <= switch_at) ? v_early : v_late;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by time %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    bit            rd;
    bit            wr;
    logic [AL-1:0] ra;
    logic [AL-1:0] wa;
    logic [WL-1:0] wd;
    int            r;

    reset_n     = 1'b0;
    read_clock  = 1'b1;
    read_from   = '0;
    write_clock = 1'b0;
    write_into  = '0;
    data        = '0;
    SW          = '0;
    exp_disp    = '0;
    exp_overrun = 1'b0;
    busy_until  = -100;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      written[i] = 1'b0;
    end

    // Reset values, with read_clock held high across release.
    repeat (2) @(posedge clock);
    #1;
    check_output("reset_q", q, 0);
    check_output("reset_read_valid", WL'(read_valid), 0);
    check_output("reset_busy", WL'(busy), 0);
    check_output("reset_overrun", WL'(overrun), 0);
    check_output("reset_displaying", displaying, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check_output("busy_strobe_held", WL'(busy), 0);
    @(posedge clock); #1;
    read_clock = 1'b0;

    $display("[TB] basic write then read");
    apply_stimulus(1'b0, 8'd0, 1'b1, 8'd5, 32'h1234);
    read_with_busy_check(8'd5);

    $display("[TB] display register");
    apply_stimulus(1'b0, 8'd0, 1'b1, AL'(DISP), 32'hCAFE);
    check_output("displaying_cafe", displaying, exp_disp);
    apply_stimulus(1'b1, AL'(DISP), 1'b0, 8'd0, 32'h0);

    $display("[TB] same-cycle write and read");
    apply_stimulus(1'b1, 8'd7, 1'b1, 8'd7, 32'h55);
    repeat (2) @(posedge clock);

    $display("[TB] switch write discarded, switch read");
    apply_stimulus(1'b0, 8'd0, 1'b1, AL'(SWA), 32'hDEAD);
    load_pattern(16'b1111_0000, 8, 17'h05A5A, 17'h05A5A, 7);
    switch_read(-1);

    $display("[TB] bouncing confirm");
    load_pattern(16'b101_1111_0000_0, 13, 17'h1ABCD, 17'h00F0F, 5);
    switch_read(-1);
    check_output("busy_after_switch", WL'(busy), 0);

    $display("[TB] overrun during switch wait");
    load_pattern(16'b1111_0000, 8, 17'h0F00F, 17'h0F00F, 7);
    switch_read(2);
    check_output("overrun_set", WL'(overrun), WL'(exp_overrun));

    $display("[TB] reset during SW_WAIT_HIGH");
    @(posedge clock); #1;
    read_clock = 1'b1;
    read_from  = AL'(SWA);
    SW         = '0;
    @(posedge clock); #1;
    read_clock = 1'b0;
    @(posedge clock); #1;
    SW = {1'b1, 17'h00123};
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_output("abort_busy", WL'(busy), 0);
    check_output("abort_read_valid", WL'(read_valid), 0);
    check_output("abort_q", q, 0);
    check_output("abort_displaying", displaying, 0);
    check_output("abort_overrun", WL'(overrun), 0);
    exp_disp    = '0;
    exp_overrun = 1'b0;
    busy_until  = -100;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    SW = '0;
    repeat (8) @(posedge clock);
    @(negedge clock);
    check_output("idle_after_abort", WL'(busy), 0);
    check_output("q_after_abort", q, 0);
    apply_stimulus(1'b1, 8'd5, 1'b0, 8'd0, 32'h0);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 150; it++) begin
      r  = $urandom_range(0, 9);
      wr = (r < 6);
      rd = (r >= 4);
      wd = $urandom;
      case ($urandom_range(0, 7))
        0:       wa = AL'(DISP);
        1:       wa = AL'(SWA);
        default: wa = AL'($urandom_range(0, 255));
      endcase
      ra = AL'($urandom_range(0, 255));
      if (ra == AL'(SWA)) ra = 8'd3;
      if (rd && r == 4) begin
        wa = ra;
        wr = 1'b1;
      end
      if (rd && !written[ra] && !(wr && wa == ra)) begin
        wa = ra;
        wr = 1'b1;
      end
      apply_stimulus(rd, ra, wr, wa, wd);
      check_output("rand_displaying", displaying, exp_disp);
      check_output("rand_overrun", WL'(overrun), WL'(exp_overrun));
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end

    repeat (6) @(posedge clock);
    #1;
    check_output("scoreboard_drained", WL'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
